mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port of the pipelined core between instruction fetch (IF) and data access (MEM).
//  Resolves the structural hazard: MEM wins by default, and an anti-starvation counter guarantees IF progress.
//  Drives per-requester stall lines and the port control. Sits beside the hazard FSM.
//  A flush from branch mispredict squashes any in-flight fetch.
// PARAMETERS
//  LAT       2  port access latency in cycles, legal range 1..15
//  MAX_WAIT  2  IF losses tolerated before IF is forced to win, legal range 1..7
// PORTS
//  clk       in   1  clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  if_req    in   1  fetch request; held until if_done or withdrawn
//  mem_req   in   1  data request; held until mem_done or withdrawn
//  mem_we    in   1  data write enable; sampled with mem_req at grant
//  flush     in   1  1-cycle mispredict flush
//  if_gnt    out  1  1-cycle pulse: fetch transaction started
//  mem_gnt   out  1  1-cycle pulse: data transaction started
//  if_done   out  1  1-cycle pulse: fetch complete (suppressed if squashed)
//  mem_done  out  1  1-cycle pulse: data complete
//  stall_if  out  1  if_req & ~if_done (combinational)
//  stall_mem out  1  mem_req & ~mem_done (combinational)
//  port_en   out  1  port busy with a transaction
//  port_sel  out  1  0 = IF, 1 = MEM; valid while port_en
//  port_we   out  1  registered mem_we of the granted MEM transaction; 0 for IF
// BEHAVIOUR
//  Reset: state IDLE. All registered outputs 0. cnt = 0, starve = 0, kill = 0. Async assert is legal mid-transaction:
//    the transaction is dropped and no done pulse follows.
//  States: IDLE, BUSY_IF, BUSY_MEM. All outputs except the stall lines are registered.
//  IDLE, at an edge:
//    - Arbitrate on the sampled requests.
//    - The IF request counts only if flush = 0 that cycle.
//    - Only MEM: go to BUSY_MEM.
//    - Only IF: go to BUSY_IF.
//    - Both, starve < MAX_WAIT: MEM wins; starve++.
//    - Both, starve == MAX_WAIT: IF wins.
//    - Any IF grant clears starve to 0. MEM alone does not change starve.
//    - On entry to BUSY_x: x_gnt = 1 for that cycle; cnt = LAT; port_en = 1; port_sel and port_we are set.
//  BUSY_x, at each edge:
//    - cnt decrements.
//    - The edge where cnt == 1 returns to IDLE and asserts x_done for one cycle. port_en = 0 in that cycle.
//    - Hence done follows gnt by exactly LAT cycles.
//  Done cycle is IDLE: requests sampled at its closing edge can be granted. The next gnt is the cycle after done.
//    Peak throughput: one transaction per LAT+1 cycles.
//  Requests are not observed while BUSY. A request dropped before its gnt is a withdrawal: no grant, no error.
//  Flush:
//    - In BUSY_IF, or in the cycle entering it: set kill.
//    - The transaction still runs to cnt expiry; port_en stays high and the port is not truncated.
//    - if_done is suppressed. kill clears on return to IDLE.
//    - Flush during BUSY_MEM has no effect.
//  Simultaneous flush and IF-only request in IDLE: no grant; stays IDLE.
//  Counters: cnt is 4 bits, starve is 3 bits. starve saturates at MAX_WAIT and never wraps.
// TESTING
//  1. Reset mid-op: rst_n low during BUSY_MEM (LAT = 3) -> all outputs 0 immediately, no mem_done afterwards;
//     a request after release is granted normally.
//  2. IF only, LAT = 2: if_req at edge 0 -> if_gnt in cycle 1, port_sel = 0, if_done in cycle 3;
//     stall_if high cycles 0-2, low in 3.
//  3. Both held, MAX_WAIT = 2 -> grant order MEM, MEM, IF, MEM, MEM, IF;
//     starve reads 0,1,2,0 at the IF grant boundaries.
//  4. mem_req + mem_we = 1 alone -> mem_gnt, port_sel = 1, port_we = 1 for LAT cycles;
//     mem_done then the port is idle.
//  5. Flush one cycle after if_gnt (LAT = 3) -> port_en stays high 3 cycles, no if_done, kill clear afterwards;
//     refetch granted next.
//  6. if_req withdrawn during BUSY_MEM -> no if_gnt is ever issued; starve unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between fetch and data.
// MEM wins by default; a starvation counter forces IF through after MAX_WAIT losses.
module mem_port_arbiter #(
  parameter int unsigned LAT      = 2,
  parameter int unsigned MAX_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic mem_req,
  input  logic mem_we,
  input  logic flush,
  output logic if_gnt,
  output logic mem_gnt,
  output logic if_done,
  output logic mem_done,
  output logic stall_if,
  output logic stall_mem,
  output logic port_en,
  output logic port_sel,
  output logic port_we
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM
  } state_t;

  localparam logic [3:0] LAT_C  = 4'(LAT);
  localparam logic [2:0] WAIT_C = 3'(MAX_WAIT);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [2:0] starve;
  logic [2:0] starve_n;
  logic       kill;
  logic       kill_n;

  logic if_gnt_n;
  logic mem_gnt_n;
  logic if_done_n;
  logic mem_done_n;
  logic port_en_n;
  logic port_sel_n;
  logic port_we_n;

  logic if_ok;
  logic if_win;
  logic last;

  // A fetch raised in a flush cycle is already stale and never competes.
  assign if_ok  = if_req & ~flush;
  assign if_win = if_ok & (~mem_req | (starve == WAIT_C));
  assign last   = (cnt == 4'd1);

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    starve_n   = starve;
    kill_n     = kill;
    if_gnt_n   = 1'b0;
    mem_gnt_n  = 1'b0;
    if_done_n  = 1'b0;
    mem_done_n = 1'b0;
    port_en_n  = port_en;
    port_sel_n = port_sel;
    port_we_n  = port_we;
    unique case (state)
      IDLE: begin
        kill_n = 1'b0;
        if (if_win) begin
          state_n    = BUSY_IF;
          if_gnt_n   = 1'b1;
          cnt_n      = LAT_C;
          starve_n   = 3'd0;
          port_en_n  = 1'b1;
          port_sel_n = 1'b0;
          port_we_n  = 1'b0;
        end else if (mem_req) begin
          state_n    = BUSY_MEM;
          mem_gnt_n  = 1'b1;
          cnt_n      = LAT_C;
          port_en_n  = 1'b1;
          port_sel_n = 1'b1;
          port_we_n  = mem_we;
          if (if_ok && (starve != WAIT_C))
            starve_n = starve + 3'd1;
        end
      end
      BUSY_IF: begin
        cnt_n = cnt - 4'd1;
        if (flush)
          kill_n = 1'b1;
        // Squashed fetch still occupies the port until expiry.
        if (last) begin
          state_n    = IDLE;
          if_done_n  = ~(kill | flush);
          kill_n     = 1'b0;
          port_en_n  = 1'b0;
          port_sel_n = 1'b0;
        end
      end
      BUSY_MEM: begin
        cnt_n = cnt - 4'd1;
        if (last) begin
          state_n    = IDLE;
          mem_done_n = 1'b1;
          port_en_n  = 1'b0;
          port_sel_n = 1'b0;
          port_we_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      starve   <= 3'd0;
      kill     <= 1'b0;
      if_gnt   <= 1'b0;
      mem_gnt  <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      port_en  <= 1'b0;
      port_sel <= 1'b0;
      port_we  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      starve   <= starve_n;
      kill     <= kill_n;
      if_gnt   <= if_gnt_n;
      mem_gnt  <= mem_gnt_n;
      if_done  <= if_done_n;
      mem_done <= mem_done_n;
      port_en  <= port_en_n;
      port_sel <= port_sel_n;
      port_we  <= port_we_n;
    end
  end

  a_gnt_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(if_gnt && mem_gnt));

  a_done_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(if_done && mem_done));

  a_we_mem: assert property (
    @(posedge clk) disable iff (!rst_n)
    port_we |-> (port_en && port_sel));

  a_starve_sat: assert property (
    @(posedge clk) disable iff (!rst_n)
    starve <= WAIT_C);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboard on the LAT=2 instance,
// directed checks on a LAT=3 instance for reset and flush.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  logic a_if_req, a_mem_req, a_mem_we, a_flush;
  logic a_if_gnt, a_mem_gnt, a_if_done, a_mem_done;
  logic a_stall_if, a_stall_mem, a_port_en, a_port_sel, a_port_we;

  logic b_if_req, b_mem_req, b_mem_we, b_flush;
  logic b_if_gnt, b_mem_gnt, b_if_done, b_mem_done;
  logic b_stall_if, b_stall_mem, b_port_en, b_port_sel, b_port_we;

  int cyc;
  int errors;
  int checks;

  typedef struct {
    bit is_mem;
    bit we;
    int cyc;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  mem_port_arbiter #(.LAT(2), .MAX_WAIT(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .mem_req(a_mem_req),
    .mem_we(a_mem_we), .flush(a_flush),
    .if_gnt(a_if_gnt), .mem_gnt(a_mem_gnt),
    .if_done(a_if_done), .mem_done(a_mem_done),
    .stall_if(a_stall_if), .stall_mem(a_stall_mem),
    .port_en(a_port_en), .port_sel(a_port_sel),
    .port_we(a_port_we)
  );

  mem_port_arbiter #(.LAT(3), .MAX_WAIT(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .mem_req(b_mem_req),
    .mem_we(b_mem_we), .flush(b_flush),
    .if_gnt(b_if_gnt), .mem_gnt(b_mem_gnt),
    .if_done(b_if_done), .mem_done(b_mem_done),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem),
    .port_en(b_port_en), .port_sel(b_port_sel),
    .port_we(b_port_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(bit m, bit we, int gc, int dc);
    exp_t e;
    e.is_mem = m;
    e.we     = we;
    e.cyc    = gc;
    gq.push_back(e);
    e.we     = 1'b0;
    e.cyc    = dc;
    dq.push_back(e);
  endtask

  // Monitor for the scoreboarded instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_if_gnt || a_mem_gnt) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 1, 0);
        end else begin
          e = gq.pop_front();
          chk("gnt_kind", int'(a_mem_gnt), int'(e.is_mem));
          chk("gnt_cycle", cyc, e.cyc);
          chk("gnt_port_en", int'(a_port_en), 1);
          chk("gnt_port_sel", int'(a_port_sel), int'(e.is_mem));
          chk("gnt_port_we", int'(a_port_we), int'(e.we));
        end
      end
      if (a_if_done || a_mem_done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = dq.pop_front();
          chk("done_kind", int'(a_mem_done), int'(e.is_mem));
          chk("done_cycle", cyc, e.cyc);
          chk("done_port_en", int'(a_port_en), 0);
        end
      end
    end
  end

  initial begin
    int c;
    int n;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    {a_if_req, a_mem_req, a_mem_we, a_flush} = '0;
    {b_if_req, b_mem_req, b_mem_we, b_flush} = '0;
    repeat (2) tick();

    chk("rst_a_outs", int'({a_if_gnt, a_mem_gnt, a_if_done, a_mem_done,
                            a_port_en, a_port_sel, a_port_we}), 0);
    chk("rst_b_outs", int'({b_if_gnt, b_mem_gnt, b_if_done, b_mem_done,
                            b_port_en, b_port_sel, b_port_we}), 0);
    chk("rst_starve", int'(u_a.starve), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Reset mid BUSY_MEM on the LAT=3 instance.
    b_mem_req = 1'b1;
    b_mem_we  = 1'b1;
    tick();
    chk("t1_gnt", int'(b_mem_gnt), 1);
    tick();
    chk("t1_busy", int'(b_port_en), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_en", int'(b_port_en), 0);
    chk("t1_rst_sel", int'(b_port_sel), 0);
    chk("t1_rst_we", int'(b_port_we), 0);
    chk("t1_rst_gd", int'({b_mem_gnt, b_mem_done}), 0);
    b_mem_req = 1'b0;
    b_mem_we  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n += int'(b_mem_done) + int'(b_port_en);
    end
    chk("t1_no_done", n, 0);
    b_mem_req = 1'b1;
    tick();
    chk("t1_regnt", int'(b_mem_gnt), 1);
    n = 0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      n += int'(b_mem_done);
      if (k == 4) begin
        chk("t1_redone", int'(b_mem_done), 1);
        b_mem_req = 1'b0;
      end
    end
    chk("t1_done_cnt", n, 1);
    repeat (2) tick();

    // IF only, LAT=2.
    c = cyc;
    a_if_req = 1'b1;
    push(1'b0, 1'b0, c + 1, c + 3);
    #1;
    chk("t2_stall_c0", int'(a_stall_if), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t2_stall", int'(a_stall_if), (k < 3) ? 1 : 0);
      if (k == 3) a_if_req = 1'b0;
    end
    repeat (2) tick();

    // MEM write alone.
    c = cyc;
    a_mem_req = 1'b1;
    a_mem_we  = 1'b1;
    push(1'b1, 1'b1, c + 1, c + 3);
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (a_port_en && a_port_sel && a_port_we) n++;
      if (k == 3) begin
        a_mem_req = 1'b0;
        a_mem_we  = 1'b0;
      end
      if (k == 4) chk("t4_idle", int'(a_port_en), 0);
    end
    chk("t4_we_cycles", n, 2);
    tick();

    // Both held: MEM, MEM, IF, MEM, MEM, IF.
    c = cyc;
    a_if_req  = 1'b1;
    a_mem_req = 1'b1;
    push(1'b1, 1'b0, c + 1,  c + 3);
    push(1'b1, 1'b0, c + 4,  c + 6);
    push(1'b0, 1'b0, c + 7,  c + 9);
    push(1'b1, 1'b0, c + 10, c + 12);
    push(1'b1, 1'b0, c + 13, c + 15);
    push(1'b0, 1'b0, c + 16, c + 18);
    chk("t3_starve_c0", int'(u_a.starve), 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      case (k)
        1, 10:  chk("t3_starve", int'(u_a.starve), 1);
        4, 13:  chk("t3_starve", int'(u_a.starve), 2);
        7, 16:  chk("t3_starve", int'(u_a.starve), 0);
        default: ;
      endcase
      if (k == 17) begin
        a_if_req  = 1'b0;
        a_mem_req = 1'b0;
      end
    end

    // IF request withdrawn while MEM owns the port.
    c = cyc;
    a_mem_req = 1'b1;
    push(1'b1, 1'b0, c + 1, c + 3);
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n += int'(a_if_gnt);
      if (k == 1) a_if_req = 1'b1;
      if (k == 2) a_if_req = 1'b0;
      if (k == 3) a_mem_req = 1'b0;
    end
    chk("t6_no_if_gnt", n, 0);
    chk("t6_starve", int'(u_a.starve), 0);

    // Flush with IF-only request in IDLE: no grant.
    a_if_req = 1'b1;
    a_flush  = 1'b1;
    #1;
    chk("fi_stall", int'(a_stall_if), 1);
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n += int'(a_if_gnt) + int'(a_port_en);
      if (k == 1) begin
        a_if_req = 1'b0;
        a_flush  = 1'b0;
      end
    end
    chk("fi_no_gnt", n, 0);

    // Flush one cycle after if_gnt, LAT=3; refetch follows.
    b_if_req = 1'b1;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 4) n += int'(b_port_en);
      if (k <= 5) chk("t5_no_done", int'(b_if_done), 0);
      case (k)
        1: chk("t5_gnt", int'(b_if_gnt), 1);
        2: b_flush = 1'b1;
        3: begin
          b_flush = 1'b0;
          chk("t5_kill_set", int'(u_b.kill), 1);
        end
        4: begin
          chk("t5_en_low", int'(b_port_en), 0);
          chk("t5_kill_clr", int'(u_b.kill), 0);
        end
        5: chk("t5_regnt", int'(b_if_gnt), 1);
        8: begin
          chk("t5_redone", int'(b_if_done), 1);
          b_if_req = 1'b0;
        end
        default: ;
      endcase
    end
    chk("t5_en_cycles", n, 3);
    repeat (3) tick();

    chk("sb_gnt_empty", gq.size(), 0);
    chk("sb_done_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
